// File: rtl/device_event_tx.sv
// Device event transmitter: turns per-device level changes into a
// round-robin stream of one-cycle on/off event strobes with a running count.
module device_event_tx #(
    parameter int N_DEV = 8,
    parameter int ID_W  = 3,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_DEV-1:0] dev_active,
    input  logic             enable,
    output logic             change,
    output logic             on_off,
    output logic [ID_W-1:0]  dev_id,
    output logic [CNT_W-1:0] active_cnt,
    output logic             idle
);

    localparam int IDX_W = ID_W + 1;

    logic [N_DEV-1:0] dev_q;
    logic [N_DEV-1:0] reported;
    logic [N_DEV-1:0] pending;
    logic [ID_W-1:0]  ptr;
    logic [ID_W-1:0]  sel;
    logic [ID_W-1:0]  ptr_next;
    logic [IDX_W-1:0] idx;
    logic             found;
    logic             issue;

    assign pending = dev_q ^ reported;
    assign issue   = enable & found;

    // Round-robin pick: first pending device at or above ptr, wrapping.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx   = '0;
        for (int i = 0; i < N_DEV; i++) begin
            idx = {1'b0, ptr} + IDX_W'(i);
            if (idx >= IDX_W'(N_DEV)) begin
                idx = idx - IDX_W'(N_DEV);
            end
            if (!found && pending[idx[ID_W-1:0]]) begin
                found = 1'b1;
                sel   = idx[ID_W-1:0];
            end
        end
    end

    // Pointer restarts just past the device that was served.
    always_comb begin
        if (sel == ID_W'(N_DEV - 1)) begin
            ptr_next = '0;
        end else begin
            ptr_next = sel + ID_W'(1);
        end
    end

    // Idle whenever every device's level has already been reported.
    always_comb begin
        idle = ~|pending;
    end

    // Input capture, event issue and active-count bookkeeping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dev_q      <= '0;
            reported   <= '0;
            ptr        <= '0;
            change     <= 1'b0;
            on_off     <= 1'b0;
            dev_id     <= '0;
            active_cnt <= '0;
        end else begin
            dev_q  <= dev_active;
            change <= 1'b0;
            if (issue) begin
                change        <= 1'b1;
                on_off        <= dev_q[sel];
                dev_id        <= sel;
                reported[sel] <= dev_q[sel];
                ptr           <= ptr_next;
                if (dev_q[sel]) begin
                    if (active_cnt != CNT_W'(N_DEV)) begin
                        active_cnt <= active_cnt + CNT_W'(1);
                    end
                end else if (active_cnt != '0) begin
                    active_cnt <= active_cnt - CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_device_event_tx.sv
// Bench for device_event_tx: directed scenarios plus random traffic,
// all checked against an event-level reference model.
module tb_device_event_tx;

    logic       clk;
    logic       rst;
    logic [7:0] dev_active;
    logic       enable;
    logic       change;
    logic       on_off;
    logic [2:0] dev_id;
    logic [3:0] active_cnt;
    logic       idle;

    int pass_cnt;
    int check_cnt;

    bit [7:0] m_q;
    bit [7:0] m_rep;
    int       m_ptr;
    int       m_cnt;
    bit       m_chg;
    bit       m_on;
    int       m_id;

    device_event_tx dut (
        .clk        (clk),
        .rst        (rst),
        .dev_active (dev_active),
        .enable     (enable),
        .change     (change),
        .on_off     (on_off),
        .dev_id     (dev_id),
        .active_cnt (active_cnt),
        .idle       (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_reset();
        m_q   = '0;
        m_rep = '0;
        m_ptr = 0;
        m_cnt = 0;
        m_chg = 1'b0;
        m_on  = 1'b0;
        m_id  = 0;
    endfunction

    // One clock edge of the specified behaviour, at event level.
    function automatic void model_edge();
        bit [7:0] pend;
        pend = m_q ^ m_rep;
        if (!rst) begin
            model_reset();
            return;
        end
        m_chg = 1'b0;
        if (enable && pend != 0) begin
            for (int k = 0; k < 8; k++) begin
                int s;
                s = (m_ptr + k) % 8;
                if (pend[s]) begin
                    m_chg    = 1'b1;
                    m_on     = m_q[s];
                    m_id     = s;
                    m_rep[s] = m_q[s];
                    m_ptr    = (s + 1) % 8;
                    m_cnt    = m_cnt + (m_on ? 1 : -1);
                    break;
                end
            end
        end
        m_q = dev_active;
    endfunction

    task automatic run_cycle();
        @(posedge clk);
        model_edge();
        #1;
        check_cnt++;
        if (change !== m_chg) begin
            $display("FAIL change: got %0b want %0b at %0t", change, m_chg, $time);
        end else begin
            pass_cnt++;
        end
        check_cnt++;
        if (active_cnt !== 4'(m_cnt)) begin
            $display("FAIL active_cnt: got %0d want %0d at %0t", active_cnt, m_cnt, $time);
        end else begin
            pass_cnt++;
        end
        check_cnt++;
        if (idle !== ((m_q ^ m_rep) == 0)) begin
            $display("FAIL idle: got %0b want %0b at %0t", idle, ((m_q ^ m_rep) == 0), $time);
        end else begin
            pass_cnt++;
        end
        if (m_chg) begin
            check_cnt++;
            if (on_off !== m_on || dev_id !== 3'(m_id)) begin
                $display("FAIL event: got on=%0b id=%0d want on=%0b id=%0d at %0t",
                         on_off, dev_id, m_on, m_id, $time);
            end else begin
                pass_cnt++;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        #1;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst        = 1'b0;
        dev_active = '0;
        enable     = 1'b1;
        model_reset();
        #3;
        check_cnt++;
        if ({change, on_off, dev_id, active_cnt} !== '0) begin
            $display("FAIL reset_out: got %0h want 0", {change, on_off, dev_id, active_cnt});
        end else begin
            pass_cnt++;
        end
        @(negedge clk);
        rst = 1'b1;
        run_cycle();
        check_cnt++;
        if (idle !== 1'b1) begin
            $display("FAIL reset_idle: got %0b want 1", idle);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic test_quiet();
        int pulses;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            run_cycle();
            if (change) pulses++;
        end
        check_cnt++;
        if (pulses != 0 || active_cnt !== 4'd0 || idle !== 1'b1) begin
            $display("FAIL quiet: got pulses=%0d cnt=%0d idle=%0b want 0 0 1",
                     pulses, active_cnt, idle);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic test_single();
        int first;
        first = -1;
        dev_active = 8'h01;
        for (int i = 1; i <= 5; i++) begin
            run_cycle();
            if (change && first < 0) first = i;
        end
        check_cnt++;
        if (first != 2 || active_cnt !== 4'd1 || idle !== 1'b1) begin
            $display("FAIL single: got edge=%0d cnt=%0d idle=%0b want 2 1 1",
                     first, active_cnt, idle);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic test_burst();
        int ids[$];
        int first;
        int last;
        do_reset();
        dev_active = 8'hFF;
        first = -1;
        last  = -1;
        for (int i = 0; i < 14; i++) begin
            run_cycle();
            if (change) begin
                ids.push_back(int'(dev_id));
                if (first < 0) first = i;
                last = i;
            end
        end
        check_cnt++;
        if (ids.size() != 8 || last - first != 7 || active_cnt !== 4'd8) begin
            $display("FAIL burst_on: got n=%0d span=%0d cnt=%0d want 8 7 8",
                     ids.size(), last - first, active_cnt);
        end else begin
            pass_cnt++;
        end
        for (int i = 0; i < ids.size(); i++) begin
            check_cnt++;
            if (ids[i] != i) begin
                $display("FAIL burst_id: got %0d want %0d", ids[i], i);
            end else begin
                pass_cnt++;
            end
        end
        ids.delete();
        dev_active = 8'h00;
        for (int i = 0; i < 14; i++) begin
            run_cycle();
            if (change && !on_off) ids.push_back(int'(dev_id));
        end
        check_cnt++;
        if (ids.size() != 8 || active_cnt !== 4'd0) begin
            $display("FAIL burst_off: got n=%0d cnt=%0d want 8 0", ids.size(), active_cnt);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic test_coalesce();
        int pulses;
        logic [3:0] cnt0;
        pulses = 0;
        cnt0   = active_cnt;
        enable = 1'b0;
        dev_active = 8'h08;
        run_cycle();
        dev_active = 8'h00;
        run_cycle();
        run_cycle();
        enable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            run_cycle();
            if (change) pulses++;
        end
        check_cnt++;
        if (pulses != 0 || active_cnt !== cnt0) begin
            $display("FAIL coalesce: got pulses=%0d cnt=%0d want 0 %0d",
                     pulses, active_cnt, cnt0);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic test_round_robin();
        int ids[$];
        do_reset();
        dev_active = 8'h10;
        for (int i = 0; i < 4; i++) begin
            run_cycle();
            if (change) ids.push_back(int'(dev_id));
        end
        dev_active = 8'h54;
        for (int i = 0; i < 6; i++) begin
            run_cycle();
            if (change) ids.push_back(int'(dev_id));
        end
        check_cnt++;
        if (ids.size() != 3 || ids[0] != 4 || ids[1] != 6 || ids[2] != 2) begin
            $display("FAIL round_robin: got n=%0d seq=%p want 4 6 2", ids.size(), ids);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic test_reset_mid_burst();
        int pulses;
        int ids[$];
        do_reset();
        dev_active = 8'hFF;
        pulses = 0;
        for (int i = 0; i < 10 && pulses < 3; i++) begin
            run_cycle();
            if (change) pulses++;
        end
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check_cnt++;
        if (pulses != 3 || {change, on_off, dev_id, active_cnt} !== '0) begin
            $display("FAIL mid_reset: got pulses=%0d out=%0h want 3 0",
                     pulses, {change, on_off, dev_id, active_cnt});
        end else begin
            pass_cnt++;
        end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 14; i++) begin
            run_cycle();
            if (change && on_off) ids.push_back(int'(dev_id));
        end
        check_cnt++;
        if (ids.size() != 8 || ids[0] != 0 || ids[7] != 7 || active_cnt !== 4'd8) begin
            $display("FAIL mid_reset_reissue: got n=%0d cnt=%0d want 8 8",
                     ids.size(), active_cnt);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                dev_active = 8'($urandom);
            end else if ($urandom_range(0, 1) == 0) begin
                dev_active = dev_active ^ (8'd1 << $urandom_range(0, 7));
            end
            enable = ($urandom_range(0, 4) != 0);
            run_cycle();
        end
        enable = 1'b1;
        for (int i = 0; i < 12; i++) run_cycle();
        check_cnt++;
        if (active_cnt !== 4'($countones(dev_active))) begin
            $display("FAIL random_settle: got %0d want %0d",
                     active_cnt, $countones(dev_active));
        end else begin
            pass_cnt++;
        end
    endtask

    initial begin
        pass_cnt  = 0;
        check_cnt = 0;
        test_reset();
        test_quiet();
        test_single();
        test_burst();
        test_coalesce();
        test_round_robin();
        test_reset_mid_burst();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/device_event_tx.md
DEVICE_EVENT_TX -- requirements
Module: device_event_tx

Interface
REQ-001 Parameter N_DEV, default 8, number of monitored IoT devices (2..16).
REQ-002 Parameter ID_W, default 3, device index width; SHALL equal ceil(log2(N_DEV)).
REQ-003 Parameter CNT_W, default 4, active-count width; SHALL hold values 0..N_DEV.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 dev_active  input  N_DEV  per-device on/off level, synchronous to clk.
REQ-007 enable  input  1  high allows event issue; low holds pending events.
REQ-008 change  output  1  one-cycle event strobe toward the device monitor.
REQ-009 on_off  output  1  event direction: 1 = device turned on, 0 = turned off.
REQ-010 dev_id  output  ID_W  index of the device that the current event refers to.
REQ-011 active_cnt  output  CNT_W  number of devices reported as on so far.
REQ-012 idle  output  1  high when no device has an unreported level change.

Function
REQ-013 dev_active SHALL be registered once into dev_q on each clock edge.
REQ-014 Register reported[N_DEV] SHALL hold the last level issued per device; pending = dev_q XOR reported.
REQ-015 Selection SHALL be round-robin: the first pending index found scanning upward from ptr, wrapping N_DEV-1 to 0.
REQ-016 On an edge where enable=1 and any pending bit is set, the block SHALL issue: change<=1, on_off<=dev_q[sel], dev_id<=sel, reported[sel]<=dev_q[sel], ptr<=(sel+1) mod N_DEV.
REQ-017 Issue rate SHALL be at most one event per cycle; change SHALL be high for exactly one cycle per event.
REQ-018 Latency SHALL be 2 cycles: a dev_active change sampled at edge t SHALL produce change=1 after edge t+1, provided the device wins arbitration and enable=1.
REQ-019 With no issue on an edge, change<=0; on_off, dev_id and ptr SHALL hold.
REQ-020 active_cnt SHALL increment on an on-event and decrement on an off-event, in the same edge as the change pulse, never leaving 0..N_DEV.
REQ-021 A device toggling and returning to its reported level before being issued SHALL clear its pending bit (coalescing); no event SHALL be emitted for it.
REQ-022 A device changing again after its event was issued SHALL become pending again and be reissued under normal arbitration.
REQ-023 enable=0 SHALL suppress issue and keep reported and ptr unchanged; pending bits continue to track dev_q.
REQ-024 idle SHALL be combinational: high when pending is all-zero.
REQ-025 The change/on_off/dev_id sequence SHALL keep a down-stream up/down counter equal to active_cnt, wrap-free.

Reset
REQ-026 rst=0 SHALL immediately force change=0, on_off=0, dev_id=0, active_cnt=0, ptr=0, dev_q=0, reported=0, independent of clk.
REQ-027 Reset asserted mid-burst SHALL discard all pending events; after release, any device still at 1 SHALL be reissued as an on-event.
REQ-028 Within one cycle of release, idle SHALL be 1 if dev_active=0.

Verification
REQ-029 Reset, dev_active=0x00, enable=1 for 10 cycles -> change=0 throughout, active_cnt=0, idle=1.
REQ-030 dev_active 0x00->0x01 sampled at edge t -> after edge t+1 change=1, on_off=1, dev_id=0 for one cycle; active_cnt=1; then idle=1.
REQ-031 dev_active 0x00->0xFF at once -> 8 consecutive pulses, dev_id 0..7, on_off=1; active_cnt steps 1..8; then 0xFF->0x00 -> 8 off-events, active_cnt returns to 0.
REQ-032 enable=0, bit 3 high one cycle then low, then enable=1 -> no change pulse; active_cnt unchanged.
REQ-033 After issuing dev_id 4 (ptr=5), bits 2 and 6 made pending together -> dev_id 6 issued first, then 2.
REQ-034 rst asserted between the 3rd and 4th pulse of the 0xFF burst -> outputs 0 immediately; after release, 8 on-events again from dev_id 0, active_cnt ends at 8.
